// File: rtl/varint_field_serializer.sv
// varint_field_serializer
//
// Serializes one object-buffer table entry at a time into protobuf wire
// format. A scalar entry reads its 64-bit value from memory at base+offset.
// It then emits the key (tag) varint followed by the value varint, one byte
// per cycle. A nested entry emits only its key, with wire type 2. A
// field_id of 0 is the end marker and produces no bytes.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   entry, entry_valid   table entry; packed as {nested, offset, field_id}
//   cpp_base_addr        base address of the current C++ object
//   ser_ready            high only while idle (entry is captured then)
//   ser_done             one-cycle pulse after an entry is fully serialized
//   mem_req_*            read request (valid/ready) with address
//   mem_resp_*           read response (valid only, no backpressure)
//   out_byte*, out_last  serialized byte stream (valid/ready)
//   dbg_state            current FSM state
//
// Handshakes: a transfer happens on a posedge where valid & ready are both
// high. A valid source holds its payload stable until the transfer happens.
// mem_resp_valid is a one-sided strobe that is honoured only while waiting.
module varint_field_serializer #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int FIELD_ID_W = 29,
  parameter int OFFSET_W   = 32,
  parameter int ENTRY_W    = FIELD_ID_W + OFFSET_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ENTRY_W-1:0] entry,
  input  logic              entry_valid,
  input  logic [ADDR_W-1:0] cpp_base_addr,
  output logic              ser_ready,
  output logic              ser_done,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [7:0]        out_byte,
  output logic              out_byte_valid,
  input  logic              out_byte_ready,
  output logic              out_last,
  output logic [2:0]        dbg_state
);

  localparam int TAG_W = FIELD_ID_W + 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_TAG  = 3'd3,
    S_VAL  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                nested_q, nested_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sh_q, sh_d;   // varint shift register (tag, then value)
  logic [DATA_W-1:0]   val_q, val_d; // field value, parked while the tag is sent

  logic [FIELD_ID_W-1:0] e_fid;
  logic [OFFSET_W-1:0]   e_off;
  logic                  e_nested;
  logic [2:0]            wire_type;
  logic                  last_grp;
  logic                  byte_xfer;

  assign e_fid     = entry[FIELD_ID_W-1:0];
  assign e_off     = entry[FIELD_ID_W +: OFFSET_W];
  assign e_nested  = entry[ENTRY_W-1];
  assign wire_type = e_nested ? 3'd2 : 3'd0;

  // The current group is the last one when nothing nonzero remains above it.
  assign last_grp  = ~|sh_q[DATA_W-1:7];
  assign byte_xfer = out_byte_valid & out_byte_ready;

  always_comb begin
    state_d  = state_q;
    nested_d = nested_q;
    addr_d   = addr_q;
    sh_d     = sh_q;
    val_d    = val_q;
    case (state_q)
      S_IDLE: begin
        if (entry_valid) begin
          nested_d = e_nested;
          // The address wraps modulo 2^ADDR_W.
          addr_d   = cpp_base_addr + {{(ADDR_W-OFFSET_W){1'b0}}, e_off};
          // The tag is loaded now so that it is ready whenever TAG begins.
          sh_d     = {{(DATA_W-TAG_W){1'b0}}, e_fid, wire_type};
          if (e_fid == '0) begin
            sh_d    = '0;
            state_d = S_DONE;
          end else if (e_nested) begin
            state_d = S_TAG;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          val_d   = mem_resp_data;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (byte_xfer) begin
          sh_d = sh_q >> 7;
          if (last_grp) begin
            if (nested_q) begin
              state_d = S_DONE;
            end else begin
              sh_d    = val_q;
              state_d = S_VAL;
            end
          end
        end
      end
      S_VAL: begin
        if (byte_xfer) begin
          sh_d = sh_q >> 7;
          if (last_grp) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      nested_q <= 1'b0;
      addr_q   <= '0;
      sh_q     <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      nested_q <= nested_d;
      addr_q   <= addr_d;
      sh_q     <= sh_d;
      val_q    <= val_d;
    end
  end

  assign ser_ready      = (state_q == S_IDLE);
  assign ser_done       = (state_q == S_DONE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = addr_q;
  assign out_byte_valid = (state_q == S_TAG) || (state_q == S_VAL);
  assign out_byte       = out_byte_valid ? {~last_grp, sh_q[6:0]} : 8'h00;
  // The final byte of the field is the last value byte for scalar entries,
  // and the last tag byte for nested entries.
  assign out_last       = out_byte_valid && last_grp &&
                          ((state_q == S_VAL) || nested_q);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_varint_field_serializer.sv
// Self-checking bench for varint_field_serializer. Expected bytes, tagged with
// their out_last flag, are queued when an entry is driven. A negedge monitor
// pops and compares them as the DUT hands bytes over.
module tb_varint_field_serializer;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int ENTRY_W = 62;
  localparam int W       = 9; // {out_last, out_byte}

  logic               clk;
  logic               reset;
  logic [ENTRY_W-1:0] entry;
  logic               entry_valid;
  logic [ADDR_W-1:0]  cpp_base_addr;
  logic               ser_ready;
  logic               ser_done;
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [DATA_W-1:0]  mem_resp_data;
  logic [7:0]         out_byte;
  logic               out_byte_valid;
  logic               out_byte_ready;
  logic               out_last;
  logic [2:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int bytes_seen = 0;
  int done_cnt   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  logic         hold_pend = 1'b0;

  varint_field_serializer dut (
    .clk(clk), .reset(reset), .entry(entry), .entry_valid(entry_valid),
    .cpp_base_addr(cpp_base_addr), .ser_ready(ser_ready), .ser_done(ser_done),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .out_byte(out_byte),
    .out_byte_valid(out_byte_valid), .out_byte_ready(out_byte_ready),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (ser_done) done_cnt++;
      if (hold_pend && out_byte_valid) begin
        n_checks++;
        if ({out_last, out_byte} !== held) begin
          n_fail++;
          $display("FAIL byte_hold: got %h required %h", {out_last, out_byte}, held);
        end
      end
      hold_pend = 1'b0;
      if (out_byte_valid && !out_byte_ready) begin
        held      = {out_last, out_byte};
        hold_pend = 1'b1;
      end
      if (out_byte_valid && out_byte_ready) begin
        bytes_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_extra: got %h required none", {out_last, out_byte});
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_byte} !== e) begin
            n_fail++;
            $display("FAIL byte_seq: got %h required %h", {out_last, out_byte}, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic last, input logic [7:0] b);
    exp_q.push_back({last, b});
  endtask

  // Reference varint encoder: 7 bits per byte, LS group first.
  task automatic push_varint(input logic [63:0] v, input logic mark_last);
    logic [63:0] r;
    logic [6:0]  g;
    r = v;
    do begin
      g = r[6:0];
      r = r >> 7;
      push_byte(mark_last && (r == 0), {(r != 0), g});
    end while (r != 0);
  endtask

  // Presents an entry for the capture cycle; returns in cycle 1.
  task automatic drive_entry(input logic [28:0] fid, input logic [31:0] off,
                             input logic nested, input logic [63:0] base);
    entry         = {nested, off, fid};
    cpp_base_addr = base;
    entry_valid   = 1'b1;
    step();
    entry_valid   = 1'b0;
    entry         = '0;
  endtask

  // Serves one read: waits for the request, stalls ready, then answers.
  // Returns the address seen, the count of stability violations during the
  // stall, and whether the request ever appeared.
  task automatic serve_mem(input int stall, input logic [63:0] data,
                           output logic [63:0] addr, output int bad,
                           output logic seen);
    int n;
    n = 0; bad = 0;
    while (!mem_req_valid && n < 50) begin step(); n++; end
    seen = mem_req_valid;
    addr = mem_req_addr;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!mem_req_valid || mem_req_addr !== addr) bad++;
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // Runs until ser_done; mode 0 ready high, 1 toggle, 2 random. cyc=-1 on timeout.
  task automatic wait_done(input int mode, output int cyc);
    cyc = 0;
    while (!ser_done && cyc < 300) begin
      if (mode == 1) out_byte_ready = ~out_byte_ready;
      if (mode == 2) out_byte_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    if (!ser_done) cyc = -1;
    out_byte_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_checks++;
    if ({ser_ready, ser_done, mem_req_valid, out_byte_valid, out_last} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 10000",
               {ser_ready, ser_done, mem_req_valid, out_byte_valid, out_last});
    end
    n_checks++;
    if (mem_req_addr !== 64'd0 || out_byte !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h byte %h required 0 0", mem_req_addr, out_byte);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_scalar(input int mem_stall, input int rmode, input string nm);
    logic [63:0] a; int bad; logic seen; int cyc; int b0;
    b0 = bytes_seen;
    push_byte(1'b0, 8'h08); push_byte(1'b0, 8'h96); push_byte(1'b1, 8'h01);
    drive_entry(29'd1, 32'd8, 1'b0, 64'h100);
    n_checks++;
    if (mem_req_valid !== 1'b1 || ser_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_req_cycle1: valid %b ready %b required 1 0", nm, mem_req_valid, ser_ready);
    end
    serve_mem(mem_stall, 64'd150, a, bad, seen);
    n_checks++;
    if (a !== 64'h108 || !seen) begin
      n_fail++;
      $display("FAIL %s_addr: got %h required 108", nm, a);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_req_hold: %0d unstable cycles required 0", nm, bad);
    end
    wait_done(rmode, cyc);
    n_checks++;
    if (rmode == 0 ? (cyc != 3) : (cyc < 3)) begin
      n_fail++;
      $display("FAIL %s_done_latency: got %0d cycles required 3", nm, cyc);
    end
    n_checks++;
    if (bytes_seen - b0 != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_byte_count: got %0d pending %0d required 3 0", nm, bytes_seen - b0, exp_q.size());
    end
    step();
    n_checks++;
    if (ser_done !== 1'b0 || ser_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done %b ready %b required 0 1", nm, ser_done, ser_ready);
    end
  endtask

  task automatic test_zero_value();
    logic [63:0] a; int bad; logic seen; int cyc;
    push_byte(1'b0, 8'h10); push_byte(1'b1, 8'h00);
    drive_entry(29'd2, 32'd0, 1'b0, 64'h2000);
    serve_mem(0, 64'd0, a, bad, seen);
    wait_done(0, cyc);
    n_checks++;
    if (cyc != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_value: cycles %0d pending %0d required 2 0", cyc, exp_q.size());
    end
    step();
  endtask

  task automatic test_max_value();
    logic [63:0] a; int bad; logic seen; int cyc; int b0;
    b0 = bytes_seen;
    push_byte(1'b0, 8'h80); push_byte(1'b0, 8'h01);
    for (int i = 0; i < 9; i++) push_byte(1'b0, 8'hFF);
    push_byte(1'b1, 8'h01);
    // Base near the top of the address space checks wrap-around.
    drive_entry(29'd16, 32'h20, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0);
    serve_mem(0, 64'hFFFF_FFFF_FFFF_FFFF, a, bad, seen);
    n_checks++;
    if (a !== 64'h10) begin
      n_fail++;
      $display("FAIL max_addr_wrap: got %h required 10", a);
    end
    wait_done(0, cyc);
    n_checks++;
    if (cyc != 12 || bytes_seen - b0 != 12) begin
      n_fail++;
      $display("FAIL max_len: cycles %0d bytes %0d required 12 12", cyc, bytes_seen - b0);
    end
    step();
  endtask

  task automatic test_nested_and_end();
    push_byte(1'b1, 8'h1A);
    drive_entry(29'd3, 32'd40, 1'b1, 64'h500);
    n_checks++;
    if ({out_byte_valid, out_last, out_byte, mem_req_valid} !== {1'b1, 1'b1, 8'h1A, 1'b0}) begin
      n_fail++;
      $display("FAIL nested_byte: got v%b l%b %h req%b required v1 l1 1a req0",
               out_byte_valid, out_last, out_byte, mem_req_valid);
    end
    step();
    n_checks++;
    if (ser_done !== 1'b1 || mem_req_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL nested_done: done %b req %b required 1 0", ser_done, mem_req_valid);
    end
    step();
    drive_entry(29'd0, 32'd8, 1'b0, 64'h100);
    n_checks++;
    if ({ser_done, ser_ready, mem_req_valid, out_byte_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL end_marker: got %b required 1000",
               {ser_done, ser_ready, mem_req_valid, out_byte_valid});
    end
    step();
    n_checks++;
    if (ser_done !== 1'b0 || ser_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL end_marker_idle: done %b ready %b required 0 1", ser_done, ser_ready);
    end
  endtask

  task automatic test_reset_mid_field();
    logic [63:0] a; int bad; logic seen; int n; int d0;
    push_byte(1'b0, 8'h80); push_byte(1'b0, 8'h01);
    for (int i = 0; i < 9; i++) push_byte(1'b0, 8'hFF);
    push_byte(1'b1, 8'h01);
    drive_entry(29'd16, 32'd0, 1'b0, 64'h0);
    serve_mem(0, 64'hFFFF_FFFF_FFFF_FFFF, a, bad, seen);
    n = bytes_seen + 4;
    while (bytes_seen < n && n < 100000) begin step(); end
    d0 = done_cnt;
    reset = 1'b0;
    step();
    n_checks++;
    if ({ser_ready, out_byte_valid, ser_done} !== 3'b100 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready/valid/done %b state %0d required 100 0",
               {ser_ready, out_byte_valid, ser_done}, dbg_state);
    end
    reset = 1'b1;
    exp_q.delete();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'($urandom);
    step();
    mem_resp_valid = 1'b0;
    step();
    n_checks++;
    if (dbg_state !== 3'd0 || ser_ready !== 1'b1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL stray_resp: state %0d ready %b dones %0d required 0 1 %0d",
               dbg_state, ser_ready, done_cnt, d0);
    end
    test_zero_value();
  endtask

  task automatic test_random();
    logic [63:0] a; int bad; logic seen; int cyc;
    logic [28:0] fid; logic [31:0] off; logic [63:0] base; logic [63:0] val;
    for (int i = 0; i < 6; i++) begin
      fid  = 29'($urandom_range(1, 32'h1FFF_FFFF));
      off  = $urandom;
      base = {$urandom, $urandom};
      val  = {$urandom, $urandom} >> $urandom_range(0, 63);
      push_varint({32'd0, fid, 3'd0}, 1'b0);
      push_varint(val, 1'b1);
      drive_entry(fid, off, 1'b0, base);
      serve_mem($urandom_range(0, 3), val, a, bad, seen);
      n_checks++;
      if (a !== base + {32'd0, off}) begin
        n_fail++;
        $display("FAIL rand_addr: got %h required %h", a, base + {32'd0, off});
      end
      wait_done(2, cyc);
      n_checks++;
      if (cyc < 0 || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rand_done: cycles %0d pending %0d required done 0", cyc, exp_q.size());
      end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    entry = '0; entry_valid = 1'b0; cpp_base_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    out_byte_ready = 1'b1; reset = 1'b0;
    test_reset();
    test_scalar(0, 0, "scalar");
    test_zero_value();
    test_max_value();
    test_nested_and_end();
    test_scalar(5, 1, "backpressure");
    test_reset_mid_field();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
